ps2_kbd_tx: RTL

Device-side PS/2 keyboard transmitter. It takes bytes (scan codes) over a valid/busy handshake and serializes each one as an 11-bit PS/2 device-to-host frame, generating both keyboard clock and data. It sits at the keyboard end of the link whose host end is the keyboard receiver in `vgaminikbd`. It is used as a synthesizable keyboard emulator, for example a scan-code replay source driven from the UART path, and as a bench stimulus model.

---
 rtl/ps2_kbd_tx.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: device-side PS/2 keyboard transmitter.
//
// Accepts a byte over a valid/busy handshake and sends it as an 11-bit
// device-to-host frame (start 0, data LSB first, odd parity, stop 1),
// driving both the PS/2 clock and data levels. A host inhibit during
// bits 0..9 aborts the frame; the byte is kept and retransmitted from the
// start bit once the inhibit is released and a 2*HALF_PERIOD gap elapses.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   dataIn       byte to send
//   dataInValid  byte request, taken only while dataInBusy=0
//   dataInBusy   high from accept until the post-frame gap ends
//   hostInhibit  host holding the PS/2 clock low (synchronous to clk)
//   kbdClk       PS/2 clock level driven by the device, idle 1
//   kbdData      PS/2 data level driven by the device, idle 1
//   txDone       one-cycle pulse when a frame completes
//   txAborted    one-cycle pulse when a frame is aborted by inhibit
//
// state    | meaning
// IDLE     | lines idle, waiting for a byte
// HOLD     | byte accepted while host inhibits, waiting for release
// BIT_HI   | clock high half of bit idx, data valid
// BIT_LO   | clock low half of bit idx, host samples on the falling edge
// GAP      | lines idle between frames or before a retransmit
// WAIT_INH | frame aborted, waiting for the host to release the clock

module ps2_kbd_tx #(
  parameter int HALF_PERIOD = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dataIn,
  input  logic       dataInValid,
  output logic       dataInBusy,
  input  logic       hostInhibit,
  output logic       kbdClk,
  output logic       kbdData,
  output logic       txDone,
  output logic       txAborted
);

  localparam int            CW       = $clog2(2 * HALF_PERIOD);
  localparam logic [CW-1:0] HALF_LD  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(2 * HALF_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    LAST_BIT = 4'd10;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    BIT_HI,
    BIT_LO,
    GAP,
    WAIT_INH
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic [3:0]    idx_nxt;
  logic [10:0]   frame;
  logic          retry;
  logic          abort_req;

  assign idx_nxt = idx + 4'd1;
  // The stop bit is never aborted: once it is on the wire the frame completes.
  assign abort_req = hostInhibit && (idx < LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      frame      <= '1;
      retry      <= 1'b0;
      dataInBusy <= 1'b0;
      kbdClk     <= 1'b1;
      kbdData    <= 1'b1;
      txDone     <= 1'b0;
      txAborted  <= 1'b0;
    end else begin
      txDone    <= 1'b0;
      txAborted <= 1'b0;
      case (state)
        IDLE: begin
          if (dataInValid) begin
            frame      <= {1'b1, ~^dataIn, dataIn, 1'b0};
            dataInBusy <= 1'b1;
            idx        <= '0;
            cnt        <= HALF_LD;
            retry      <= 1'b0;
            if (hostInhibit) begin
              state <= HOLD;
            end else begin
              state   <= BIT_HI;
              kbdData <= 1'b0;
            end
          end
        end

        HOLD: begin
          if (!hostInhibit) begin
            state   <= BIT_HI;
            idx     <= '0;
            cnt     <= HALF_LD;
            kbdClk  <= 1'b1;
            kbdData <= frame[0];
          end
        end

        BIT_HI: begin
          if (abort_req) begin
            state     <= WAIT_INH;
            kbdClk    <= 1'b1;
            kbdData   <= 1'b1;
            txAborted <= 1'b1;
          end else if (cnt == '0) begin
            state  <= BIT_LO;
            cnt    <= HALF_LD;
            kbdClk <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        BIT_LO: begin
          if (abort_req) begin
            state     <= WAIT_INH;
            kbdClk    <= 1'b1;
            kbdData   <= 1'b1;
            txAborted <= 1'b1;
          end else if (cnt == '0) begin
            kbdClk <= 1'b1;
            if (idx < LAST_BIT) begin
              state   <= BIT_HI;
              idx     <= idx_nxt;
              cnt     <= HALF_LD;
              kbdData <= frame[idx_nxt];
            end else begin
              state   <= GAP;
              cnt     <= GAP_LD;
              kbdData <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        GAP: begin
          // txDone is raised one cycle early so it lands on the last busy cycle.
          if (cnt == CNT_ONE && !retry) begin
            txDone <= 1'b1;
          end
          if (cnt == '0) begin
            if (retry) begin
              state   <= BIT_HI;
              retry   <= 1'b0;
              idx     <= '0;
              cnt     <= HALF_LD;
              kbdData <= frame[0];
            end else begin
              state      <= IDLE;
              dataInBusy <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        WAIT_INH: begin
          if (!hostInhibit) begin
            state <= GAP;
            cnt   <= GAP_LD;
            retry <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
